// File: rtl/img_pkg.sv
// Shared definitions for the image-pyramid scaler path: eot bit positions,
// fixed-point unity, FSM state type and accumulator sizing.
package img_pkg;

    localparam int unsigned EOT_ROW            = 0;
    localparam int unsigned EOT_FRAME          = 1;
    localparam int unsigned SCALE_FRAC_DEFAULT = 8;
    localparam int unsigned SCALE_ONE          = 1 << SCALE_FRAC_DEFAULT;

    typedef enum logic {
        IDLE,
        ACTIVE
    } scaler_state_e;

    function automatic int unsigned acc_width(input int unsigned w,
                                              input int unsigned h,
                                              input int unsigned frac);
        int unsigned m;
        m = (w > h) ? w : h;
        return $clog2(m) + frac + 2;
    endfunction

endpackage

// File: rtl/dreg.sv
// Single valid/ready register slice; payload is held while stalled.
module dreg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/img_scaler_nn.sv
// Nearest-neighbour downscaler: keeps pixels where the column/row counters
// meet the fixed-point accumulators and re-emits them with regenerated eot.
module img_scaler_nn
    import img_pkg::*;
#(
    parameter int unsigned W_DATA     = 8,
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned SCALE_FRAC = SCALE_FRAC_DEFAULT,
    parameter int unsigned W_SCALE    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_SCALE-1:0] scale,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic [W_DATA-1:0]  din_data,
    input  logic [1:0]         din_eot,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [W_DATA-1:0]  dout_data,
    output logic [1:0]         dout_eot,
    output logic               eot_err
);

    localparam int unsigned ACC_W = acc_width(IMG_WIDTH, IMG_HEIGHT, SCALE_FRAC);
    localparam int unsigned SUM_W = ((ACC_W > W_SCALE) ? ACC_W : W_SCALE) + 1;
    localparam int unsigned COL_W = $clog2(IMG_WIDTH + 1);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT + 1);
    localparam logic [W_SCALE-1:0] ONE   = W_SCALE'(1) << SCALE_FRAC;
    localparam logic [ACC_W-1:0]   X_SAT = ACC_W'(IMG_WIDTH) << SCALE_FRAC;
    localparam logic [ACC_W-1:0]   Y_SAT = ACC_W'(IMG_HEIGHT) << SCALE_FRAC;

    scaler_state_e      state_q, state_d;
    logic [W_SCALE-1:0] scale_q, scale_eff, scale_cur;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic [ACC_W-1:0]   x_acc_q, y_acc_q, x_acc_nxt, y_acc_nxt;
    logic [SUM_W-1:0]   x_sum, y_sum;
    logic               accept, keep_col, keep_row, kept;
    logic               col_end, row_end, row_done, frame_done;
    logic               last_col, last_row;
    logic [1:0]         exp_eot, kept_eot;

    assign accept = din_valid && din_ready;

    always_comb begin
        scale_eff = (scale < ONE) ? ONE : scale;
        // IDLE uses the live (clamped) scale so the first pixel needs no bubble.
        scale_cur = (state_q == IDLE) ? scale_eff : scale_q;
        x_sum     = SUM_W'(x_acc_q) + SUM_W'(scale_cur);
        y_sum     = SUM_W'(y_acc_q) + SUM_W'(scale_cur);
        keep_col  = SUM_W'(col_q) == SUM_W'(x_acc_q >> SCALE_FRAC);
        keep_row  = SUM_W'(row_q) == SUM_W'(y_acc_q >> SCALE_FRAC);
        kept      = keep_col && keep_row;
        last_col  = (x_sum >> SCALE_FRAC) >= SUM_W'(IMG_WIDTH);
        last_row  = (y_sum >> SCALE_FRAC) >= SUM_W'(IMG_HEIGHT);
        col_end   = col_q == COL_W'(IMG_WIDTH - 1);
        row_end   = row_q == ROW_W'(IMG_HEIGHT - 1);

        exp_eot            = '0;
        exp_eot[EOT_ROW]   = col_end;
        exp_eot[EOT_FRAME] = col_end && row_end;

        // Input eot flags override the counters so a misaligned stream resyncs.
        row_done   = col_end || din_eot[EOT_ROW] || din_eot[EOT_FRAME];
        frame_done = (col_end && row_end) || din_eot[EOT_FRAME];

        kept_eot            = '0;
        kept_eot[EOT_ROW]   = last_col || row_done;
        kept_eot[EOT_FRAME] = (last_col && last_row) || frame_done;

        // Saturating at the frame edge is equivalent to unbounded growth and avoids wrap.
        x_acc_nxt = (x_sum >= SUM_W'(X_SAT)) ? X_SAT : x_sum[ACC_W-1:0];
        y_acc_nxt = (y_sum >= SUM_W'(Y_SAT)) ? Y_SAT : y_sum[ACC_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !frame_done) state_d = ACTIVE;
            ACTIVE:  if (accept && frame_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            scale_q <= ONE;
            col_q   <= '0;
            row_q   <= '0;
            x_acc_q <= '0;
            y_acc_q <= '0;
            eot_err <= 1'b0;
        end else begin
            state_q <= state_d;
            eot_err <= accept && (din_eot != exp_eot);
            if (accept) begin
                if (state_q == IDLE) begin
                    scale_q <= scale_eff;
                end
                if (frame_done) begin
                    col_q   <= '0;
                    row_q   <= '0;
                    x_acc_q <= '0;
                    y_acc_q <= '0;
                end else if (row_done) begin
                    col_q   <= '0;
                    x_acc_q <= '0;
                    row_q   <= row_q + ROW_W'(1);
                    if (keep_row) begin
                        y_acc_q <= y_acc_nxt;
                    end
                end else begin
                    col_q <= col_q + COL_W'(1);
                    if (keep_col) begin
                        x_acc_q <= x_acc_nxt;
                    end
                end
            end
        end
    end

    dreg #(
        .W(W_DATA + 2)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .in_valid (din_valid && kept),
        .in_ready (din_ready),
        .in_data  ({kept_eot, din_data}),
        .out_valid(dout_valid),
        .out_ready(dout_ready),
        .out_data ({dout_eot, dout_data})
    );

endmodule

// File: tb/tb_img_scaler_nn.sv
// Directed bench for img_scaler_nn on an 8x4 frame: scale factors, stalls,
// eot resync, clamp and mid-frame reset.
module tb_img_scaler_nn;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] scale = 16'd0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [7:0]  din_data = 8'd0;
    logic [1:0]  din_eot = 2'b00;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic [7:0]  dout_data;
    logic [1:0]  dout_eot;
    logic        eot_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [9:0]  outq[$];
    logic [9:0]  expq[$];
    int          err_cnt, stall_bad, rdy_bad;
    logic        timed_out;
    logic [7:0]  base;

    always #5 clk = ~clk;

    img_scaler_nn #(
        .W_DATA    (8),
        .IMG_WIDTH (8),
        .IMG_HEIGHT(4),
        .SCALE_FRAC(8),
        .W_SCALE   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scale     (scale),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_data  (din_data),
        .din_eot   (din_eot),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data),
        .dout_eot  (dout_eot),
        .eot_err   (eot_err)
    );

    // Drives one frame (optionally with an early row end at row 0, or aborted
    // after pixel stop_at is accepted) and records every transferred output.
    task automatic run_frame(input logic [15:0] scl, input int bp, input int early, input int stop_at);
        int row = 0, col = 0, idx = 0, cyc = 0, tail = 0, row_len;
        logic acc, stalled = 1'b0, drain;
        logic [9:0] held = '0;
        outq.delete();
        err_cnt = 0; stall_bad = 0; rdy_bad = 0; timed_out = 1'b0;
        scale = scl;
        while (1) begin
            drain   = (row >= 4);
            row_len = (early >= 0 && row == 0) ? early + 1 : 8;
            if (drain || bp == 0) dout_ready = 1'b1;
            else dout_ready = (cyc >= 10 && cyc < 15) ? 1'b0 : (cyc % 2 == 0);
            din_valid = !drain;
            din_data  = base + 8'(row * 8 + col);
            din_eot   = drain ? 2'b00 : {(col == row_len - 1) && (row == 3), col == row_len - 1};
            @(negedge clk);
            if (stalled && (!dout_valid || {dout_eot, dout_data} !== held)) stall_bad++;
            if (din_ready !== (!dout_valid || dout_ready)) rdy_bad++;
            if (dout_valid && dout_ready) outq.push_back({dout_eot, dout_data});
            if (eot_err) err_cnt++;
            acc     = din_valid && din_ready;
            stalled = dout_valid && !dout_ready;
            held    = {dout_eot, dout_data};
            @(posedge clk); #1;
            cyc++;
            if (acc && idx == stop_at) break;
            if (acc) begin
                idx++;
                if (col == row_len - 1) begin col = 0; row++; end
                else col++;
            end
            if (drain) tail++;
            if (tail >= 4) break;
            if (cyc >= 400) begin timed_out = 1'b1; break; end
        end
        din_valid  = 1'b0;
        din_eot    = 2'b00;
        dout_ready = 1'b1;
    endtask

    task automatic test_reset();
        vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", dout_valid); end
        vectors++; if (dout_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h want 00", dout_data); end
        vectors++; if (dout_eot !== 2'b00) begin miscompares++; $display("FAIL rst_eot: got %b want 00", dout_eot); end
        vectors++; if (eot_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", eot_err); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        vectors++; if (din_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", din_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_pass_through();
        base = 8'h00;
        run_frame(16'd256, 0, -1, -1);
        expq.delete();
        for (int p = 0; p < 32; p++) expq.push_back({p == 31, p % 8 == 7, 8'(p)});
        vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL pass_timeout: got %b want 0", timed_out); end
        vectors++; if (outq.size() != expq.size()) begin miscompares++; $display("FAIL pass_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            vectors++;
            if (outq[i] !== expq[i]) begin miscompares++; $display("FAIL pass_pix[%0d]: got %h want %h", i, outq[i], expq[i]); end
        end
        vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL pass_err: got %0d want 0", err_cnt); end
        vectors++; if (rdy_bad != 0) begin miscompares++; $display("FAIL pass_ready: got %0d bad cycles want 0", rdy_bad); end
    endtask

    task automatic test_half_scale();
        int cols[4] = '{0, 2, 4, 6};
        int rows[2] = '{0, 2};
        base = 8'h40;
        run_frame(16'd512, 0, -1, -1);
        expq.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                expq.push_back({c == 3 && r == 1, c == 3, base + 8'(rows[r] * 8 + cols[c])});
        vectors++; if (outq.size() != expq.size()) begin miscompares++; $display("FAIL half_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            vectors++;
            if (outq[i] !== expq[i]) begin miscompares++; $display("FAIL half_pix[%0d]: got %h want %h", i, outq[i], expq[i]); end
        end
        vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL half_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_scale_1p5();
        int cols[6] = '{0, 1, 3, 4, 6, 7};
        int rows[3] = '{0, 1, 3};
        base = 8'h60;
        run_frame(16'd384, 0, -1, -1);
        expq.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 6; c++)
                expq.push_back({c == 5 && r == 2, c == 5, base + 8'(rows[r] * 8 + cols[c])});
        vectors++; if (outq.size() != expq.size()) begin miscompares++; $display("FAIL s15_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            vectors++;
            if (outq[i] !== expq[i]) begin miscompares++; $display("FAIL s15_pix[%0d]: got %h want %h", i, outq[i], expq[i]); end
        end
    endtask

    task automatic test_backpressure();
        base = 8'h80;
        run_frame(16'd256, 1, -1, -1);
        expq.delete();
        for (int p = 0; p < 32; p++) expq.push_back({p == 31, p % 8 == 7, base + 8'(p)});
        vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL bp_timeout: got %b want 0", timed_out); end
        vectors++; if (outq.size() != expq.size()) begin miscompares++; $display("FAIL bp_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            vectors++;
            if (outq[i] !== expq[i]) begin miscompares++; $display("FAIL bp_pix[%0d]: got %h want %h", i, outq[i], expq[i]); end
        end
        vectors++; if (stall_bad != 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_bad); end
        vectors++; if (rdy_bad != 0) begin miscompares++; $display("FAIL bp_ready: got %0d bad cycles want 0", rdy_bad); end
    endtask

    task automatic test_eot_misalign_clamp();
        base = 8'h10;
        run_frame(16'd100, 0, 5, -1);
        expq.delete();
        for (int p = 0; p < 32; p++)
            if (p != 6 && p != 7) expq.push_back({p == 31, (p % 8 == 7) || (p == 5), base + 8'(p)});
        vectors++; if (outq.size() != expq.size()) begin miscompares++; $display("FAIL mis_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            vectors++;
            if (outq[i] !== expq[i]) begin miscompares++; $display("FAIL mis_pix[%0d]: got %h want %h", i, outq[i], expq[i]); end
        end
        vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL mis_err: got %0d pulse cycles want 1", err_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int cols[4] = '{0, 2, 4, 6};
        int rows[2] = '{0, 2};
        base = 8'h20;
        run_frame(16'd256, 0, -1, 13);
        rst = 1'b0;
        #1;
        vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", dout_valid); end
        vectors++; if (dout_eot !== 2'b00) begin miscompares++; $display("FAIL mid_rst_eot: got %b want 00", dout_eot); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        base = 8'h30;
        run_frame(16'd512, 0, -1, -1);
        expq.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                expq.push_back({c == 3 && r == 1, c == 3, base + 8'(rows[r] * 8 + cols[c])});
        vectors++; if (outq.size() != expq.size()) begin miscompares++; $display("FAIL mid_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            vectors++;
            if (outq[i] !== expq[i]) begin miscompares++; $display("FAIL mid_pix[%0d]: got %h want %h", i, outq[i], expq[i]); end
        end
        vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL mid_err: got %0d want 0", err_cnt); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_pass_through();
        test_half_scale();
        test_scale_1p5();
        test_backpressure();
        test_eot_misalign_clamp();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
